bcd7_conv_scheduler: RTL

- Shares one 7-digit double-dabble converter (24-bit magnitude in, 28-bit BCD out, 1-cycle start/done, busy flag) between N_REQ display requesters, such as the FFT magnitude readout, calculator result and status counters.
- Arbitrates requests round-robin and latches signed input.
- Computes magnitude with saturation to 9,999,999.
- Sequences the converter and returns tagged BCD results to the 7-segment display formatter.

---
 rtl/bcd7_conv_scheduler_if.sv | 35 +++
 rtl/bcd7_conv_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd7_conv_scheduler_if.sv
// rtl/bcd7_conv_scheduler_if.sv - requester, converter and result signals of the BCD conversion scheduler
interface bcd7_conv_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    i_req;
    logic [32*N_REQ-1:0] i_val;
    logic [N_REQ-1:0]    o_ack;
    logic                o_conv_start;
    logic [23:0]         o_conv_val;
    logic                i_conv_busy;
    logic                i_conv_done;
    logic [27:0]         i_conv_bcd;
    logic                o_res_valid;
    logic [ID_W-1:0]     o_res_id;
    logic [27:0]         o_res_bcd;
    logic                o_res_neg;
    logic                o_res_sat;
    logic                o_res_err;
    logic                o_busy;

    // Scheduler side
    modport slave (
        input  i_req, i_val, i_conv_busy, i_conv_done, i_conv_bcd,
        output o_ack, o_conv_start, o_conv_val, o_res_valid, o_res_id,
               o_res_bcd, o_res_neg, o_res_sat, o_res_err, o_busy
    );

    // Requesters, converter and display formatter side
    modport master (
        output i_req, i_val, i_conv_busy, i_conv_done, i_conv_bcd,
        input  o_ack, o_conv_start, o_conv_val, o_res_valid, o_res_id,
               o_res_bcd, o_res_neg, o_res_sat, o_res_err, o_busy
    );
endinterface

// File: rtl/bcd7_conv_scheduler.sv
// rtl/bcd7_conv_scheduler.sv - round-robin sharing of one 7-digit BCD converter with sign/saturation handling
module bcd7_conv_scheduler #(
    parameter int N_REQ       = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 63
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    bcd7_conv_scheduler_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    localparam logic [23:0]     SAT_MAX   = 24'd9999999;
    localparam logic [7:0]      TMO_LAST  = 8'(TIMEOUT_CYC - 1);
    localparam logic [ID_W-1:0] LAST_INIT = ID_W'(N_REQ - 1);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [ID_W-1:0]    cur_id_q, cur_id_d;
    logic [31:0]        val_q, val_d;
    logic [7:0]         tmo_q, tmo_d;
    logic               neg_q, neg_d;
    logic               sat_q, sat_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               conv_start_q, conv_start_d;
    logic [23:0]        conv_val_q, conv_val_d;
    logic               res_valid_q, res_valid_d;
    logic [ID_W-1:0]    res_id_q, res_id_d;
    logic [27:0]        res_bcd_q, res_bcd_d;
    logic               res_neg_q, res_neg_d;
    logic               res_sat_q, res_sat_d;
    logic               res_err_q, res_err_d;
    logic               busy_q, busy_d;

    logic               gnt_found;
    logic [ID_W-1:0]    gnt_id;
    logic [N_REQ-1:0]   gnt_oh;
    logic [31:0]        gnt_val;
    logic [32:0]        mag_ext;
    logic [32:0]        mag;
    logic               sat_cond;
    logic [23:0]        sat_val;

    // Round-robin pick: first requester above last_grant, then wrap to the lowest index
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        gnt_oh    = '0;
        gnt_val   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!gnt_found && bus.i_req[k] && (k > int'(last_grant_q))) begin
                gnt_found = 1'b1;
                gnt_id    = ID_W'(k);
                gnt_oh[k] = 1'b1;
                gnt_val   = bus.i_val[32*k +: 32];
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (!gnt_found && bus.i_req[k] && (k <= int'(last_grant_q))) begin
                gnt_found = 1'b1;
                gnt_id    = ID_W'(k);
                gnt_oh[k] = 1'b1;
                gnt_val   = bus.i_val[32*k +: 32];
            end
        end
    end

    // Magnitude at 33 bits so that -2^31 negates cleanly, then clip to seven digits
    always_comb begin
        mag_ext  = {val_q[31], val_q};
        mag      = val_q[31] ? (33'd0 - mag_ext) : mag_ext;
        sat_cond = (mag > 33'd9999999);
        sat_val  = sat_cond ? SAT_MAX : mag[23:0];
    end

    // Next-state and next-output logic; pulse outputs default low every cycle
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cur_id_d     = cur_id_q;
        val_d        = val_q;
        tmo_d        = tmo_q;
        neg_d        = neg_q;
        sat_d        = sat_q;
        ack_d        = '0;
        conv_start_d = 1'b0;
        conv_val_d   = conv_val_q;
        res_valid_d  = 1'b0;
        res_id_d     = res_id_q;
        res_bcd_d    = res_bcd_q;
        res_neg_d    = res_neg_q;
        res_sat_d    = res_sat_q;
        res_err_d    = res_err_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_found) begin
                    val_d        = gnt_val;
                    cur_id_d     = gnt_id;
                    last_grant_d = gnt_id;
                    ack_d        = gnt_oh;
                    state_d      = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!bus.i_conv_busy) begin
                    conv_start_d = 1'b1;
                    conv_val_d   = sat_val;
                    neg_d        = val_q[31];
                    sat_d        = sat_cond;
                    tmo_d        = '0;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.i_conv_done) begin
                    res_valid_d = 1'b1;
                    res_id_d    = cur_id_q;
                    res_bcd_d   = bus.i_conv_bcd;
                    res_neg_d   = neg_q;
                    res_sat_d   = sat_q;
                    res_err_d   = 1'b0;
                    state_d     = ST_OUT;
                end else if (tmo_q == TMO_LAST) begin
                    res_valid_d = 1'b1;
                    res_id_d    = cur_id_q;
                    res_bcd_d   = '0;
                    res_neg_d   = neg_q;
                    res_sat_d   = sat_q;
                    res_err_d   = 1'b1;
                    state_d     = ST_OUT;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_OUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= LAST_INIT;
            cur_id_q     <= '0;
            val_q        <= '0;
            tmo_q        <= '0;
            neg_q        <= 1'b0;
            sat_q        <= 1'b0;
            ack_q        <= '0;
            conv_start_q <= 1'b0;
            conv_val_q   <= '0;
            res_valid_q  <= 1'b0;
            res_id_q     <= '0;
            res_bcd_q    <= '0;
            res_neg_q    <= 1'b0;
            res_sat_q    <= 1'b0;
            res_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_id_q     <= cur_id_d;
            val_q        <= val_d;
            tmo_q        <= tmo_d;
            neg_q        <= neg_d;
            sat_q        <= sat_d;
            ack_q        <= ack_d;
            conv_start_q <= conv_start_d;
            conv_val_q   <= conv_val_d;
            res_valid_q  <= res_valid_d;
            res_id_q     <= res_id_d;
            res_bcd_q    <= res_bcd_d;
            res_neg_q    <= res_neg_d;
            res_sat_q    <= res_sat_d;
            res_err_q    <= res_err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.o_ack        = ack_q;
    assign bus.o_conv_start = conv_start_q;
    assign bus.o_conv_val   = conv_val_q;
    assign bus.o_res_valid  = res_valid_q;
    assign bus.o_res_id     = res_id_q;
    assign bus.o_res_bcd    = res_bcd_q;
    assign bus.o_res_neg    = res_neg_q;
    assign bus.o_res_sat    = res_sat_q;
    assign bus.o_res_err    = res_err_q;
    assign bus.o_busy       = busy_q;
endmodule
